// File: rtl/execute_stage_muldiv.sv
// Execute stage with an EX/MEM pipeline register.
//   - operand forwarding, ALU, RISC-V branch compare and PC redirect
//   - iterative radix-2 multiply / restoring divide (M extension)
//   - stall request to the hazard unit while the mul/div unit is busy
//   - flush and bubble insertion into the M stage
//
// Ports:
//   clk, rst (async, active low)
//   ValidE, FlushE                 E-stage valid / kill
//   RegWriteE, MemWriteE, BranchE, JumpE, ResultSrcE, ALUControlE,
//   MulDivE, MulDivOpE, BranchOpE, ALUSrcAE, ALUSrcBE,
//   ForwardAE, ForwardBE           decoded controls and forward selects
//   RD1E, RD2E, PCE, ImmExtE, PCPlus4E, ResultW, RdE   operands
//   StallE                         holds IF/ID/EX while mul/div is busy
//   PCSrcE, PCTargetE              fetch redirect
//   RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM,
//   PCPlus4M, RdM                  registered M-stage outputs
//
// Mul/div FSM:
//   state | meaning
//   IDLE  | no operation in flight; a mul/div in E is latched and started
//   BUSY  | one shift-add / restoring-subtract step per cycle
//   DONE  | last step done combinationally, result offered to M

module execute_stage_muldiv #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int CNTW = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ValidE,
    input  logic            FlushE,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            BranchE,
    input  logic            JumpE,
    input  logic [1:0]      ResultSrcE,
    input  logic [3:0]      ALUControlE,
    input  logic            MulDivE,
    input  logic [2:0]      MulDivOpE,
    input  logic [2:0]      BranchOpE,
    input  logic [1:0]      ALUSrcAE,
    input  logic [1:0]      ALUSrcBE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [XLEN-1:0] ResultW,
    input  logic [REGW-1:0] RdE,
    output logic            StallE,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [REGW-1:0] RdM
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [XLEN-1:0] fwdA, fwdB, srcA, srcB, aluResult, mdResult, eResult;
    logic [SHW-1:0]  shamt;
    logic            cond, start, bubble;

    always_comb begin
        case (ForwardAE)
            2'b01:   fwdA = ResultW;
            2'b10:   fwdA = ALUResultM;
            default: fwdA = RD1E;
        endcase
        case (ForwardBE)
            2'b01:   fwdB = ResultW;
            2'b10:   fwdB = ALUResultM;
            default: fwdB = RD2E;
        endcase
        case (ALUSrcAE)
            2'b01:   srcA = '0;
            2'b10:   srcA = PCE;
            default: srcA = fwdA;
        endcase
        case (ALUSrcBE)
            2'b00:   srcB = fwdB;
            2'b10:   srcB = PCTargetE;
            default: srcB = ImmExtE;
        endcase
    end

    assign shamt     = srcB[SHW-1:0];
    assign PCTargetE = PCE + ImmExtE;

    always_comb begin
        aluResult = '0;
        case (ALUControlE)
            4'd0: aluResult = srcA + srcB;
            4'd1: aluResult = srcA - srcB;
            4'd2: aluResult = srcA & srcB;
            4'd3: aluResult = srcA | srcB;
            4'd4: aluResult = srcA ^ srcB;
            4'd5: aluResult = {{(XLEN-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
            4'd6: aluResult = {{(XLEN-1){1'b0}}, (srcA < srcB)};
            4'd7: aluResult = srcA << shamt;
            4'd8: aluResult = srcA >> shamt;
            4'd9: aluResult = $signed(srcA) >>> shamt;
            default: aluResult = '0;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (BranchOpE)
            3'b000:  cond = (fwdA == fwdB);
            3'b001:  cond = (fwdA != fwdB);
            3'b100:  cond = ($signed(fwdA) <  $signed(fwdB));
            3'b101:  cond = ($signed(fwdA) >= $signed(fwdB));
            3'b110:  cond = (fwdA <  fwdB);
            3'b111:  cond = (fwdA >= fwdB);
            default: cond = 1'b0;
        endcase
    end

    assign PCSrcE = ValidE & ~FlushE & (JumpE | (BranchE & cond));

    // Mul/div unit: works on magnitudes, signs are applied to the result.
    // hi/lo are the product halves for multiply, remainder/quotient for divide.
    logic [1:0]      state, stateNext;
    logic [CNTW-1:0] cnt;
    logic [XLEN-1:0] hi, lo, mag;
    logic [2:0]      opLat;
    logic            negRes, negRem, divZero;

    logic            aSigned, bSigned, negA, negB;
    logic [XLEN-1:0] magA, magB;

    assign aSigned = (MulDivOpE == 3'b001) | (MulDivOpE == 3'b010) |
                     (MulDivOpE == 3'b100) | (MulDivOpE == 3'b110);
    assign bSigned = (MulDivOpE == 3'b001) | (MulDivOpE == 3'b100) |
                     (MulDivOpE == 3'b110);
    assign negA    = aSigned & fwdA[XLEN-1];
    assign negB    = bSigned & fwdB[XLEN-1];
    assign magA    = negA ? -fwdA : fwdA;
    assign magB    = negB ? -fwdB : fwdB;
    assign start   = (state == IDLE) & ValidE & MulDivE & ~FlushE;

    logic [XLEN:0]   addT, divShift, divDiff;
    logic [XLEN-1:0] hiStep, loStep;

    always_comb begin
        addT     = lo[0] ? ({1'b0, hi} + {1'b0, mag}) : {1'b0, hi};
        divShift = {hi, lo[XLEN-1]};
        divDiff  = divShift - {1'b0, mag};
        if (opLat[2]) begin
            // A clear top bit means no borrow: the divisor fits, quotient bit 1.
            if (!divDiff[XLEN]) begin
                hiStep = divDiff[XLEN-1:0];
                loStep = {lo[XLEN-2:0], 1'b1};
            end else begin
                hiStep = divShift[XLEN-1:0];
                loStep = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hiStep = addT[XLEN:1];
            loStep = {addT[0], lo[XLEN-1:1]};
        end
    end

    // The final step is not registered: DONE uses the step output directly,
    // so XLEN-1 registered steps plus this one give the full XLEN iterations.
    logic [2*XLEN-1:0] prod, prodS;
    logic [XLEN-1:0]   quo, remRes;

    always_comb begin
        prod     = {hiStep, loStep};
        prodS    = negRes ? -prod : prod;
        quo      = negRes ? -loStep : loStep;
        remRes   = negRem ? -hiStep : hiStep;
        mdResult = '0;
        case (opLat)
            3'b000:                mdResult = prodS[XLEN-1:0];
            3'b001, 3'b010, 3'b011: mdResult = prodS[2*XLEN-1:XLEN];
            3'b100, 3'b101:        mdResult = divZero ? '1 : quo;
            default:               mdResult = remRes;
        endcase
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (start) stateNext = BUSY;
            BUSY: begin
                if (FlushE)                 stateNext = IDLE;
                else if (cnt == CNTW'(2))   stateNext = DONE;
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            mag     <= '0;
            opLat   <= '0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
        end else begin
            state <= stateNext;
            if (start) begin
                cnt     <= CNTW'(XLEN);
                hi      <= '0;
                lo      <= magA;
                mag     <= magB;
                opLat   <= MulDivOpE;
                negRes  <= negA ^ negB;
                negRem  <= negA;
                divZero <= (fwdB == '0);
            end else if (state == BUSY) begin
                cnt <= cnt - CNTW'(1);
                hi  <= hiStep;
                lo  <= loStep;
            end
        end
    end

    // rst gates the start term so no stall is requested while held in reset.
    assign StallE = rst & ~FlushE & (start | (state == BUSY));

    assign bubble  = ~ValidE | FlushE | StallE;
    assign eResult = MulDivE ? mdResult : aluResult;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
            RdM        <= '0;
        end else if (bubble) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
            RdM        <= '0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            ALUResultM <= eResult;
            WriteDataM <= fwdB;
            PCPlus4M   <= PCPlus4E;
            RdM        <= RdE;
        end
    end

endmodule

// File: tb/tb_execute_stage_muldiv.sv
// Self-checking bench for execute_stage_muldiv: a 32-bit instance for ALU,
// branch, mul/div, flush and reset behaviour, plus a 64-bit instance for
// wide multiply/divide. Expected values come from plain-arithmetic models.

module tb_execute_stage_muldiv;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        ValidE, FlushE, ValidE64, FlushE64;
    logic        RegWriteE, MemWriteE, BranchE, JumpE, MulDivE;
    logic [1:0]  ResultSrcE, ALUSrcAE, ALUSrcBE, ForwardAE, ForwardBE;
    logic [3:0]  ALUControlE;
    logic [2:0]  MulDivOpE, BranchOpE;
    logic [4:0]  RdE;
    logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E, ResultW;

    logic        StallE, PCSrcE, RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;

    logic [63:0] RD1E64, RD2E64;
    logic [63:0] zero64 = '0;
    logic        StallE64, PCSrcE64, RegWriteM64, MemWriteM64;
    logic [1:0]  ResultSrcM64;
    logic [63:0] PCTargetE64, ALUResultM64, WriteDataM64, PCPlus4M64;
    logic [4:0]  RdM64;

    execute_stage_muldiv #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .ValidE(ValidE), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .MulDivE(MulDivE),
        .MulDivOpE(MulDivOpE), .BranchOpE(BranchOpE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
        .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E), .ResultW(ResultW), .RdE(RdE),
        .StallE(StallE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM)
    );

    execute_stage_muldiv #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .ValidE(ValidE64), .FlushE(FlushE64),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .MulDivE(MulDivE),
        .MulDivOpE(MulDivOpE), .BranchOpE(BranchOpE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .RD1E(RD1E64), .RD2E(RD2E64), .PCE(zero64),
        .ImmExtE(zero64), .PCPlus4E(zero64), .ResultW(zero64), .RdE(RdE),
        .StallE(StallE64), .PCSrcE(PCSrcE64), .PCTargetE(PCTargetE64), .RegWriteM(RegWriteM64),
        .MemWriteM(MemWriteM64), .ResultSrcM(ResultSrcM64), .ALUResultM(ALUResultM64),
        .WriteDataM(WriteDataM64), .PCPlus4M(PCPlus4M64), .RdM(RdM64)
    );

    int          nCompared = 0;
    int          nMismatched = 0;
    logic [31:0] modelM;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return (a < b) ? 32'd1 : 32'd0;
            4'd7: return a << sh;
            4'd8: return a >> sh;
            4'd9: return $signed(a) >>> sh;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic refBranch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return $signed(a) < $signed(b);
            3'b101: return $signed(a) >= $signed(b);
            3'b110: return a < b;
            3'b111: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] refMulDiv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        logic   ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [63:0] ref64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        p = {64'd0, a} * {64'd0, b};
        case (op)
            3'd0: return p[63:0];
            3'd3: return p[127:64];
            3'd5: return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
            3'd7: return (b == 0) ? a : a % b;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    task automatic idleInputs();
        ValidE = 0; FlushE = 0; ValidE64 = 0; FlushE64 = 0;
        RegWriteE = 0; MemWriteE = 0; BranchE = 0; JumpE = 0; MulDivE = 0;
        ResultSrcE = 0; ALUSrcAE = 0; ALUSrcBE = 0; ForwardAE = 0; ForwardBE = 0;
        ALUControlE = 0; MulDivOpE = 0; BranchOpE = 0; RdE = 0;
        RD1E = 0; RD2E = 0; PCE = 0; ImmExtE = 0; PCPlus4E = 0; ResultW = 0;
        RD1E64 = 0; RD2E64 = 0;
    endtask

    task automatic doAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] fa, input logic [31:0] exp, input string tag);
        ValidE = 1; FlushE = 0; MulDivE = 0; BranchE = 0; JumpE = 0;
        ALUControlE = op; ForwardAE = fa; ForwardBE = 0; ALUSrcAE = 0; ALUSrcBE = 0;
        RegWriteE = 1; MemWriteE = 0; ResultSrcE = 0; RdE = 5'd3; RD1E = a; RD2E = b;
        #1;
        checkVal({tag, "_stall"}, StallE, 0);
        @(posedge clk); #1;
        checkVal(tag, ALUResultM, exp);
        checkVal({tag, "_we"}, RegWriteM, 1);
        modelM = exp;
    endtask

    task automatic runMd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] exp;
        logic [4:0]  rd;
        int          stalls, guard, sel;
        exp = refMulDiv(op, a, b);
        rd  = 5'($urandom_range(1, 31));
        ValidE = 1; FlushE = 0; MulDivE = 1; MulDivOpE = op; RegWriteE = 1; MemWriteE = 0;
        BranchE = 0; JumpE = 0; RdE = rd; ALUSrcAE = 0; ALUSrcBE = 0; ALUControlE = 0;
        RD1E = a; RD2E = b; ForwardAE = 0; ForwardBE = 0; ResultW = $urandom;
        sel = $urandom_range(0, 2);
        if (sel == 1) begin ForwardAE = 2'b01; ResultW = a; RD1E = ~a; end
        else if (sel == 2) begin ForwardBE = 2'b01; ResultW = b; RD2E = ~b; end
        stalls = 0; guard = 0;
        #2;
        while (StallE === 1'b1 && guard < 200) begin
            stalls++; guard++;
            @(posedge clk); #1;
            checkVal({tag, "_bubble"}, RegWriteM, 0);
            // operands must be held internally; disturb the forward sources
            RD1E = $urandom; RD2E = $urandom; ResultW = $urandom;
            #1;
        end
        checkVal({tag, "_stalls"}, stalls, 32);
        @(posedge clk); #1;
        checkVal(tag, ALUResultM, exp);
        checkVal({tag, "_rd"}, RdM, rd);
        checkVal({tag, "_we"}, RegWriteM, 1);
        ValidE = 0; MulDivE = 0;
        modelM = exp;
    endtask

    task automatic runMd64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input string tag);
        logic [63:0] exp;
        int          stalls, guard;
        exp = ref64(op, a, b);
        ValidE = 0; ValidE64 = 1; FlushE64 = 0; MulDivE = 1; MulDivOpE = op; RegWriteE = 1;
        MemWriteE = 0; BranchE = 0; JumpE = 0; RdE = 5'd9; ForwardAE = 0; ForwardBE = 0;
        RD1E64 = a; RD2E64 = b;
        stalls = 0; guard = 0;
        #2;
        while (StallE64 === 1'b1 && guard < 300) begin
            stalls++; guard++;
            @(posedge clk); #1;
            checkVal({tag, "_bubble"}, RegWriteM64, 0);
            #1;
        end
        checkVal({tag, "_stalls"}, stalls, 64);
        @(posedge clk); #1;
        checkVal(tag, ALUResultM64, exp);
        checkVal({tag, "_we"}, RegWriteM64, 1);
        ValidE64 = 0; MulDivE = 0;
    endtask

    initial begin
        logic [31:0] fa, fb, sa, sb, tgt, exp;
        logic        bub;
        int          guard;
        logic [2:0]  ops64 [4];
        ops64 = '{3'd0, 3'd3, 3'd5, 3'd7};

        // reset with a mul/div request present: no stall, M cleared
        idleInputs();
        rst = 0;
        ValidE = 1; MulDivE = 1; ValidE64 = 1;
        #12;
        checkVal("rst_stall", StallE, 0);
        checkVal("rst_stall64", StallE64, 0);
        checkVal("rst_alu", ALUResultM, 0);
        checkVal("rst_we", RegWriteM, 0);
        checkVal("rst_rd", RdM, 0);
        idleInputs();
        @(posedge clk); #1;
        rst = 1;
        modelM = 0;
        @(posedge clk); #1;

        // directed ALU
        doAlu(4'd0, 32'd2, 32'd3, 2'b00, 32'd5, "add_pre");
        doAlu(4'd0, 32'd99, 32'd7, 2'b10, 32'd12, "add_fwdM");
        rst = 0; #1;
        checkVal("async_rst_alu", ALUResultM, 0);
        checkVal("async_rst_we", RegWriteM, 0);
        #2; rst = 1; modelM = 0;
        @(posedge clk); #1;
        doAlu(4'd9, 32'h8000_0000, 32'd4, 2'b00, 32'hF800_0000, "sra");

        // branch compares
        ValidE = 1; BranchE = 1; JumpE = 0; BranchOpE = 3'b100; ForwardAE = 0; ForwardBE = 0;
        RD1E = 32'hFFFF_FFFF; RD2E = 32'd1; PCE = 32'h0000_1000; ImmExtE = 32'h20;
        #2;
        checkVal("blt_pcsrc", PCSrcE, 1);
        checkVal("blt_target", PCTargetE, 32'h0000_1020);
        BranchOpE = 3'b110; #1;
        checkVal("bltu_pcsrc", PCSrcE, 0);
        BranchOpE = 3'b100; FlushE = 1; #1;
        checkVal("blt_flushed", PCSrcE, 0);
        FlushE = 0; BranchE = 0; ValidE = 0;
        @(posedge clk); #1;
        modelM = 0;

        // directed mul/div
        runMd(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
        runMd(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
        runMd(3'd4, 32'd7, 32'd0, "div_by0");
        runMd(3'd6, 32'd7, 32'd0, "rem_by0");
        runMd(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        runMd(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        runMd(3'd5, 32'd100, 32'd7, "divu");
        runMd(3'd7, 32'd100, 32'd7, "remu");

        // flush in BUSY cycle 5
        ValidE = 1; MulDivE = 1; MulDivOpE = 3'd5; ForwardAE = 0; ForwardBE = 0;
        RD1E = 32'd100; RD2E = 32'd7; RegWriteE = 1; RdE = 5'd4;
        repeat (5) @(posedge clk);
        #1;
        FlushE = 1; #1;
        checkVal("flush_busy_stall", StallE, 0);
        @(posedge clk); #1;
        checkVal("flush_busy_we", RegWriteM, 0);
        FlushE = 0;
        doAlu(4'd0, 32'd3, 32'd4, 2'b00, 32'd7, "after_flush");

        // flush in DONE: nothing written, unit returns to idle
        ValidE = 1; MulDivE = 1; MulDivOpE = 3'd0; ForwardAE = 0; ForwardBE = 0;
        RD1E = 32'd3; RD2E = 32'd5; RegWriteE = 1; RdE = 5'd6;
        guard = 0; #2;
        while (StallE === 1'b1 && guard < 200) begin @(posedge clk); #1; guard++; end
        checkVal("flush_done_reached", (guard < 200), 1);
        FlushE = 1;
        @(posedge clk); #1;
        checkVal("flush_done_we", RegWriteM, 0);
        checkVal("flush_done_res", ALUResultM, 0);
        FlushE = 0; ValidE = 0; MulDivE = 0; modelM = 0;
        runMd(3'd0, 32'd6, 32'd7, "mul_after_flush");

        // reset in the middle of a divide
        ValidE = 1; MulDivE = 1; MulDivOpE = 3'd4; ForwardAE = 0; ForwardBE = 0;
        RD1E = 32'd1000; RD2E = 32'd3; RegWriteE = 1; RdE = 5'd8;
        repeat (10) @(posedge clk);
        #1;
        rst = 0; #1;
        checkVal("rst_busy_stall", StallE, 0);
        checkVal("rst_busy_we", RegWriteM, 0);
        checkVal("rst_busy_alu", ALUResultM, 0);
        checkVal("rst_busy_rd", RdM, 0);
        ValidE = 0; MulDivE = 0;
        #2; rst = 1; #1;
        checkVal("rst_release_stall", StallE, 0);
        @(posedge clk); #1;
        modelM = 0;
        runMd(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_after_rst");

        // random ALU / branch traffic with forwarding and bubbles
        for (int i = 0; i < 200; i++) begin
            ValidE = ($urandom_range(0, 7) != 0);
            FlushE = ($urandom_range(0, 9) == 0);
            MulDivE = 0;
            ALUControlE = 4'($urandom_range(0, 11));
            ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
            ALUSrcAE = 2'($urandom); ALUSrcBE = 2'($urandom);
            BranchE = 1'($urandom); JumpE = ($urandom_range(0, 7) == 0);
            BranchOpE = 3'($urandom);
            RegWriteE = 1'($urandom); MemWriteE = 1'($urandom);
            ResultSrcE = 2'($urandom); RdE = 5'($urandom);
            RD1E = randOperand(); RD2E = randOperand(); ResultW = randOperand();
            PCE = $urandom; ImmExtE = $urandom; PCPlus4E = $urandom;
            fa  = (ForwardAE == 2'b01) ? ResultW : (ForwardAE == 2'b10) ? modelM : RD1E;
            fb  = (ForwardBE == 2'b01) ? ResultW : (ForwardBE == 2'b10) ? modelM : RD2E;
            tgt = PCE + ImmExtE;
            sa  = (ALUSrcAE == 2'b01) ? 32'd0 : (ALUSrcAE == 2'b10) ? PCE : fa;
            sb  = (ALUSrcBE == 2'b00) ? fb : (ALUSrcBE == 2'b10) ? tgt : ImmExtE;
            exp = refAlu(ALUControlE, sa, sb);
            bub = !ValidE || FlushE;
            #2;
            checkVal("rnd_target", PCTargetE, tgt);
            checkVal("rnd_pcsrc", PCSrcE, ValidE && !FlushE && (JumpE || (BranchE && refBranch(BranchOpE, fa, fb))));
            checkVal("rnd_stall", StallE, 0);
            @(posedge clk); #1;
            checkVal("rnd_we", RegWriteM, bub ? 1'b0 : RegWriteE);
            checkVal("rnd_mw", MemWriteM, bub ? 1'b0 : MemWriteE);
            checkVal("rnd_rs", ResultSrcM, bub ? 2'd0 : ResultSrcE);
            checkVal("rnd_rd", RdM, bub ? 5'd0 : RdE);
            checkVal("rnd_alu", ALUResultM, bub ? 32'd0 : exp);
            checkVal("rnd_wd", WriteDataM, bub ? 32'd0 : fb);
            checkVal("rnd_pc4", PCPlus4M, bub ? 32'd0 : PCPlus4E);
            modelM = bub ? 32'd0 : exp;
        end
        idleInputs();
        @(posedge clk); #1;
        modelM = 0;

        // random mul/div
        for (int i = 0; i < 24; i++) begin
            runMd(3'($urandom_range(0, 7)), randOperand(), randOperand(), "rnd_md");
        end

        // 64-bit instance
        runMd64(3'd0, 64'h1_0000_0000, 64'h1_0000_0000, "mul64_lo");
        runMd64(3'd3, 64'h1_0000_0000, 64'h1_0000_0000, "mulhu64_hi");
        for (int i = 0; i < 4; i++) begin
            runMd64(ops64[i], {$urandom, $urandom}, {32'd0, $urandom}, "rnd_md64");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/execute_stage_muldiv.md
Name: execute_stage_muldiv

Overview:
Parametrised EX stage of the 5-stage pipeline, with an EX/MEM pipeline register.
- Generalises the current execute stage in data width.
- Adds full RISC-V branch compares, an iterative multiply/divide unit (M extension) and a stall handshake to the hazard unit.
- Adds flush and bubble insertion into MEM.
- Sits between the ID/EX register and the memory stage; drives PC redirect to fetch.

Parameters:
XLEN, 32, datapath width; legal values 32 and 64.
REGW, 5, register index width.
CNTW, $clog2(XLEN)+1, iteration counter width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
ValidE  in  1  E-stage instruction valid
FlushE  in  1  kill E-stage instruction, including any in-flight mul/div
RegWriteE, MemWriteE, BranchE, JumpE  in  1 each  decoded controls
ResultSrcE  in  2  writeback select, passed to M
ALUControlE  in  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra; others give 0
MulDivE  in  1  instruction is M-extension
MulDivOpE  in  3  funct3: mul, mulh, mulhsu, mulhu, div, divu, rem, remu
BranchOpE  in  3  funct3: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu
ALUSrcAE  in  2  00 forwarded A, 01 zero, 10 PCE, 11 forwarded A
ALUSrcBE  in  2  00 forwarded B, 01 ImmExtE, 10 PCTargetE, 11 ImmExtE
ForwardAE, ForwardBE  in  2  00 RD1E/RD2E, 01 ResultW, 10 ALUResultM, 11 RD1E/RD2E
RD1E, RD2E, PCE, ImmExtE, PCPlus4E, ResultW  in  XLEN  operands
RdE  in  REGW  destination register
StallE  out  1  combinational; holds IF/ID/EX while mul/div is busy
PCSrcE  out  1  redirect fetch
PCTargetE  out  XLEN  PCE+ImmExtE, modulo 2^XLEN
RegWriteM, MemWriteM  out  1  registered controls
ResultSrcM  out  2  registered
ALUResultM, WriteDataM, PCPlus4M  out  XLEN  registered
RdM  out  REGW  registered

Behaviour:
Reset:
- rst=0 asynchronously clears all M outputs to 0 and puts the FSM in IDLE.
- StallE=0 while in reset.

Datapath:
- Forward muxes feed SrcA/SrcB.
- WriteDataM captures the forwarded B value, before the ALUSrcB mux.
- Shift amount is SrcB[$clog2(XLEN)-1:0].
- slt/sltu produce 0 or 1, zero-extended.

Branch:
- cond per BranchOpE, computed on the forwarded A/B values; undefined BranchOpE means not taken.
- PCSrcE = ValidE & ~FlushE & (JumpE | (BranchE & cond)).

Mul/div FSM, states IDLE, BUSY, DONE:
- IDLE: on ValidE & MulDivE & ~FlushE, latch operands (signed/unsigned per op), set cnt=XLEN, go to BUSY. StallE=1 in that same cycle.
- BUSY: one radix-2 shift-add or restoring-subtract step per cycle; cnt decrements; StallE=1. When cnt reaches 1, go to DONE.
- DONE: StallE=0; result drives the E result; the next edge captures it into M. Return to IDLE.
- Total E occupancy is XLEN+1 cycles (StallE high for XLEN cycles).
- mul returns the low XLEN bits of the product; mulh/mulhsu/mulhu return the high XLEN bits.
- Divide by zero: quotient all ones, remainder = dividend.
- Signed overflow (-2^(XLEN-1) / -1): quotient = dividend, remainder = 0.
- Special cases still take the full XLEN+1 cycles.
- FlushE in BUSY or DONE aborts: next state IDLE, StallE drops combinationally, and no result is written to M.

EX/MEM register:
- On ~ValidE | FlushE | StallE, M gets a bubble: RegWriteM=0, MemWriteM=0, ResultSrcM=0, RdM=0; data fields are don't-care but are zeroed.
- Otherwise M captures E. E result = mul/div result if MulDivE, else ALU result.

Simultaneous events:
- rst dominates FlushE.
- FlushE dominates a mul/div start and the DONE capture.
- Forward muxes are sampled only at mul/div start; operands are held internally afterwards.

Test Plan:
- Reset mid-BUSY (cycle 10 of a div): rst=0 -> all M outputs 0, StallE=0; first cycle after release, StallE=0, FSM in IDLE.
- add with ForwardAE=10, ALUResultM=5, RD2E=7 -> ALUResultM=12 next cycle. sra with A=0x80000000, B=4 -> 0xF8000000.
- blt with A=-1, B=1, BranchE=1 -> PCSrcE=1 and PCTargetE=PCE+ImmExtE. Same operands with bltu -> PCSrcE=0.
- mulhu 0xFFFFFFFF×0xFFFFFFFF -> StallE high 32 cycles, then ALUResultM=0xFFFFFFFE. mul with the same operands -> 0x00000001. Bubbles appear in M during the stall.
- div 7/0 -> 0xFFFFFFFF; rem 7/0 -> 7; div 0x80000000/-1 -> 0x80000000; rem 0x80000000/-1 -> 0. divu 100/7 -> 14; remu 100/7 -> 2.
- FlushE at BUSY cycle 5 -> StallE=0 the same cycle; RegWriteM stays 0; the next instruction is accepted normally. Repeat with XLEN=64: mul 2^32×2^32 -> low=0, high=1.
